// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: funct3 size codes, FSM states, MMIO map.
// No logic; imported by dmem_align and dmem_ctrl.
package dmem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

    localparam logic [3:0]  MMIO_BASE    = 4'hF;
    localparam logic [27:0] MMIO_OFF_CYC = 28'h000_0000;
    localparam logic [27:0] MMIO_OFF_OUT = 28'h000_0004;

endpackage

// File: rtl/dmem_align.sv
// Byte-lane alignment: store lane enables and replicated store word, load extraction/extension, misaligned/illegal detection.
// Purely combinational, zero latency, no flow control.
module dmem_align
    import dmem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wword,
    output logic [31:0] rdata,
    output logic        err
);

    logic        illegal;
    logic        misal;
    logic [31:0] shifted;

    always_comb begin
        illegal = 1'b0;
        misal   = 1'b0;
        byte_en = 4'b0000;
        wword   = wdata;
        shifted = rword >> {addr_lo, 3'b000};
        rdata   = rword;
        case (funct3)
            F3_LB, F3_LBU: begin
                byte_en = 4'b0001 << addr_lo;
                wword   = {4{wdata[7:0]}};
                rdata   = {{24{shifted[7] & ~funct3[2]}}, shifted[7:0]};
            end
            F3_LH, F3_LHU: begin
                misal   = addr_lo[0];
                byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword   = {2{wdata[15:0]}};
                rdata   = {{16{shifted[15] & ~funct3[2]}}, shifted[15:0]};
            end
            F3_LW: begin
                misal   = |addr_lo;
                byte_en = 4'b1111;
            end
            default: illegal = 1'b1;
        endcase
        // Unsigned variants exist only for loads.
        if (we && funct3[2]) begin
            illegal = 1'b1;
        end
        err = illegal | misal;
        if (err) begin
            byte_en = 4'b0000;
            rdata   = 32'h0;
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: req/ready handshake, accept-to-ready latency WAIT_STATES+1, one access in flight (req held until ready).
// Optional MMIO window at addr[31:28]=F (cycle counter, output register) when DMEM_MMIO_EN is defined.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int    DEPTH_WORDS = 256,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int         AW    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS_M1 = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [31:0] mem [DEPTH_WORDS];

    dmem_state_t state, state_nx;
    logic [3:0]  cnt, cnt_nx;

    logic          we_q;
    logic [2:0]    f3_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rword_q;
    logic [31:0]   rword_src;
    logic          accept;

    logic [3:0]  byte_en;
    logic [31:0] wword;
    logic [31:0] ext_rdata;
    logic        align_err;
    logic        acc_err;
    logic        commit;
    logic        arr_commit;

    assign accept = (state == ST_IDLE) && req;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (WAIT_STATES > 0) begin
                        state_nx = ST_WAIT;
                        cnt_nx   = WS_M1;
                    end else begin
                        state_nx = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = ST_RESP;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // The addressed word is captured at accept, so later input changes cannot disturb the access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rword_q <= 32'h0;
        end else if (accept) begin
            we_q    <= we;
            f3_q    <= funct3;
            addr_q  <= addr[AW+1:0];
            wdata_q <= wdata;
            rword_q <= rword_src;
        end
    end

    dmem_align u_align (
        .we      (we_q),
        .funct3  (f3_q),
        .addr_lo (addr_q[1:0]),
        .wdata   (wdata_q),
        .rword   (rword_q),
        .byte_en (byte_en),
        .wword   (wword),
        .rdata   (ext_rdata),
        .err     (align_err)
    );

    assign commit = (state == ST_RESP) && we_q && !acc_err;

`ifdef DMEM_MMIO_EN
    logic        is_mmio;
    logic        mmio_q;
    logic        mmio_cyc_q;
    logic        mmio_out_q;
    logic [31:0] cyc_cnt;
    logic [31:0] out_reg;

    assign is_mmio = (addr[31:28] == MMIO_BASE);

    always_comb begin
        rword_src = mem[addr[AW+1:2]];
        if (is_mmio) begin
            if (addr[27:0] == MMIO_OFF_CYC) begin
                rword_src = cyc_cnt;
            end else if (addr[27:0] == MMIO_OFF_OUT) begin
                rword_src = out_reg;
            end else begin
                rword_src = 32'h0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mmio_q     <= 1'b0;
            mmio_cyc_q <= 1'b0;
            mmio_out_q <= 1'b0;
        end else if (accept) begin
            mmio_q     <= is_mmio;
            mmio_cyc_q <= is_mmio && (addr[27:0] == MMIO_OFF_CYC);
            mmio_out_q <= is_mmio && (addr[27:0] == MMIO_OFF_OUT);
        end
    end

    // Unmapped MMIO offsets never flag an error; the output register accepts whole words only.
    always_comb begin
        acc_err = align_err;
        if (mmio_q && !mmio_cyc_q && !mmio_out_q) begin
            acc_err = 1'b0;
        end else if (mmio_out_q && (f3_q != F3_LW)) begin
            acc_err = 1'b1;
        end
    end

    assign arr_commit = commit && !mmio_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_cnt <= 32'h0;
            out_reg <= 32'h0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (commit && mmio_out_q) begin
                out_reg <= wdata_q;
            end
        end
    end
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:AW+2];

    assign rword_src  = mem[addr[AW+1:2]];
    assign acc_err    = align_err;
    assign arr_commit = commit;
`endif

    always_ff @(posedge clk) begin
        if (arr_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[addr_q[AW+1:2]][8*i +: 8] <= wword[8*i +: 8];
                end
            end
        end
    end

    assign ready = (state == ST_RESP);
    assign err   = ready && acc_err;
    assign rdata = (ready && !we_q && !acc_err) ? ext_rdata : 32'h0;

endmodule
